// File: rtl/image_frame_arbiter.sv
// -----------------------------------------------------------------------------
// image_frame_arbiter
//
// Purpose:
//   Shares one downstream image stream (vs/hs/en/data) between two camera
//   sources. A source is granted only at a frame boundary. The whole granted
//   frame is then passed through with one register stage. Traffic from the
//   source that is not granted is dropped. Grants alternate round-robin
//   between the enabled sources. A start-of-frame timeout stops a silent
//   source from starving the other one.
//
// Stream semantics:
//   There is no backpressure. vs is high for the whole frame, hs marks a line,
//   and en qualifies data on the cycle it is high. The downstream consumer
//   must accept every cycle. hs/en/data are forwarded as-is and are never
//   checked against vs.
//
// Ports:
//   I_clk, I_rst            clock; synchronous active-high reset
//   I_cam0_vs/hs/en/data    source 0 stream
//   I_cam1_vs/hs/en/data    source 1 stream
//   I_src_enable[1:0]       bit n = source n may be granted
//   O_image_vs/hs/en/data   arbitrated stream, 1 cycle behind the source
//   O_sel                   granted source (meaningful while O_busy=1)
//   O_busy                  high in WAIT_SOF or STREAM
//   O_frame_cnt             frames fully delivered, wraps
//   O_timeout               1-cycle pulse when a grant is abandoned
// -----------------------------------------------------------------------------
module image_frame_arbiter #(
  parameter int Pra_Width    = 8,
  parameter int Pra_Timeout  = 1000000,
  parameter int Pra_CntWidth = 16
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic                    I_cam0_vs,
  input  logic                    I_cam0_hs,
  input  logic                    I_cam0_en,
  input  logic [Pra_Width-1:0]    I_cam0_data,
  input  logic                    I_cam1_vs,
  input  logic                    I_cam1_hs,
  input  logic                    I_cam1_en,
  input  logic [Pra_Width-1:0]    I_cam1_data,
  input  logic [1:0]              I_src_enable,
  output logic                    O_image_vs,
  output logic                    O_image_hs,
  output logic                    O_image_en,
  output logic [Pra_Width-1:0]    O_image_data,
  output logic                    O_sel,
  output logic                    O_busy,
  output logic [Pra_CntWidth-1:0] O_frame_cnt,
  output logic                    O_timeout
);

  // The timeout counter only has to reach Pra_Timeout-1.
  localparam int TW = (Pra_Timeout > 1) ? $clog2(Pra_Timeout) : 1;
  localparam logic [TW-1:0] TLAST = TW'(Pra_Timeout - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_STREAM   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  logic [1:0]              r_vs_d;
  logic                    r_sel;
  logic                    r_last_sel;
  logic [TW-1:0]           r_tcnt;
  logic [Pra_CntWidth-1:0] r_frame_cnt;
  logic                    r_timeout;
  logic                    r_img_vs;
  logic                    r_img_hs;
  logic                    r_img_en;
  logic [Pra_Width-1:0]    r_img_data;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t                  w_state_nxt;
  logic                    w_sel_nxt;
  logic                    w_last_sel_nxt;
  logic [TW-1:0]           w_tcnt_nxt;
  logic                    w_timeout_nxt;
  logic                    w_cnt_inc;
  logic                    w_pass;

  logic [1:0]              w_vs;
  logic [1:0]              w_sof;
  logic [1:0]              w_eof;
  logic                    w_sel_sof;
  logic                    w_sel_eof;
  logic                    w_src_vs;
  logic                    w_src_hs;
  logic                    w_src_en;
  logic [Pra_Width-1:0]    w_src_data;

  // Both sources are edge-tracked all the time. A source granted while its vs
  // is already high therefore never shows a false SOF, so it cannot join a
  // frame halfway through.
  assign w_vs  = {I_cam1_vs, I_cam0_vs};
  assign w_sof = w_vs & ~r_vs_d;
  assign w_eof = ~w_vs & r_vs_d;

  assign w_sel_sof  = r_sel ? w_sof[1] : w_sof[0];
  assign w_sel_eof  = r_sel ? w_eof[1] : w_eof[0];

  assign w_src_vs   = r_sel ? I_cam1_vs   : I_cam0_vs;
  assign w_src_hs   = r_sel ? I_cam1_hs   : I_cam0_hs;
  assign w_src_en   = r_sel ? I_cam1_en   : I_cam0_en;
  assign w_src_data = r_sel ? I_cam1_data : I_cam0_data;

  // ---------------------------------------------------------------------------
  // FSM next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_last_sel_nxt = r_last_sel;
    w_tcnt_nxt     = r_tcnt;
    w_timeout_nxt  = 1'b0;
    w_cnt_inc      = 1'b0;
    w_pass         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|I_src_enable) begin
          // Prefer the source that was not served last. Fall back to the
          // same source when the other one is disabled.
          if (I_src_enable[~r_last_sel]) begin
            w_sel_nxt = ~r_last_sel;
          end else begin
            w_sel_nxt = r_last_sel;
          end
          w_tcnt_nxt  = '0;
          w_state_nxt = ST_WAIT_SOF;
        end
      end

      ST_WAIT_SOF: begin
        if (w_sel_sof) begin
          // The SOF cycle itself belongs to the frame, so it is forwarded.
          w_pass      = 1'b1;
          w_state_nxt = ST_STREAM;
        end else if (!I_src_enable[r_sel]) begin
          // The grant is withdrawn. last_sel is left alone, so the
          // round-robin order is not disturbed.
          w_state_nxt = ST_IDLE;
        end else if (r_tcnt == TLAST) begin
          // Count the silent source as served so that the other source is
          // preferred next.
          w_last_sel_nxt = r_sel;
          w_timeout_nxt  = 1'b1;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end

      ST_STREAM: begin
        // Enable changes are ignored here. A frame that has started always
        // completes, and the EOF cycle (vs low) is still forwarded.
        w_pass = 1'b1;
        if (w_sel_eof) begin
          w_cnt_inc      = 1'b1;
          w_last_sel_nxt = r_sel;
          w_state_nxt    = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state     <= ST_IDLE;
      r_vs_d      <= 2'b00;
      r_sel       <= 1'b0;
      r_last_sel  <= 1'b1;    // source 0 wins the first arbitration
      r_tcnt      <= '0;
      r_frame_cnt <= '0;
      r_timeout   <= 1'b0;
      r_img_vs    <= 1'b0;
      r_img_hs    <= 1'b0;
      r_img_en    <= 1'b0;
      r_img_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_vs_d     <= w_vs;
      r_sel      <= w_sel_nxt;
      r_last_sel <= w_last_sel_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_timeout  <= w_timeout_nxt;
      if (w_cnt_inc) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_pass) begin
        r_img_vs   <= w_src_vs;
        r_img_hs   <= w_src_hs;
        r_img_en   <= w_src_en;
        r_img_data <= w_src_data;
      end else begin
        r_img_vs   <= 1'b0;
        r_img_hs   <= 1'b0;
        r_img_en   <= 1'b0;
        r_img_data <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign O_image_vs   = r_img_vs;
  assign O_image_hs   = r_img_hs;
  assign O_image_en   = r_img_en;
  assign O_image_data = r_img_data;
  assign O_sel        = r_sel;
  assign O_busy       = (r_state != ST_IDLE);
  assign O_frame_cnt  = r_frame_cnt;
  assign O_timeout    = r_timeout;

endmodule

// File: doc/image_frame_arbiter.md
Name: image_frame_arbiter

Overview:
- Frame-level arbiter sharing one downstream image stream (vs/hs/en/data bundle) between two camera sources.
- Grants a source only at a frame boundary and passes that whole frame through with one register stage. Non-granted traffic is dropped.
- Round-robin between enabled sources; a start-of-frame timeout prevents a dead source from starving the other.
- Sits between the sensor capture front-ends and the ORB/FAST pipeline input.

Parameters:
- Pra_Width, 8, pixel data width.
- Pra_Timeout, 1000000, cycles to wait for SOF after grant before abandoning it (must be ≥ 1).
- Pra_CntWidth, 16, width of the delivered-frame counter.

Ports:
- I_clk  input  1  single clock for all logic.
- I_rst  input  1  synchronous, active-high reset.
- I_cam0_vs  input  1  source 0 frame-active (high for the whole frame).
- I_cam0_hs  input  1  source 0 line-active.
- I_cam0_en  input  1  source 0 pixel valid.
- I_cam0_data  input  Pra_Width  source 0 pixel.
- I_cam1_vs / I_cam1_hs / I_cam1_en / I_cam1_data  input  1/1/1/Pra_Width  same fields for source 1.
- I_src_enable  input  2  bit n = source n may be granted.
- O_image_vs  output  1  arbitrated frame-active.
- O_image_hs  output  1  arbitrated line-active.
- O_image_en  output  1  arbitrated pixel valid.
- O_image_data  output  Pra_Width  arbitrated pixel.
- O_sel  output  1  currently granted source (valid when O_busy=1).
- O_busy  output  1  high in WAIT_SOF or STREAM.
- O_frame_cnt  output  Pra_CntWidth  frames fully delivered; wraps modulo 2^Pra_CntWidth.
- O_timeout  output  1  one-cycle pulse when a grant is abandoned.

Behaviour:
- Edge detection: per-source registered vs_d.
  - SOF = vs & ~vs_d.
  - EOF = ~vs & vs_d.
- Reset (I_rst=1 at a clock edge):
  - state=IDLE; all O_image_* = 0; O_sel=0; O_busy=0; O_timeout=0; O_frame_cnt=0.
  - last_sel=1, so source 0 is preferred first; vs_d=0.
  - Reset mid-frame truncates the output frame immediately; no EOF is synthesized.
- FSM states: IDLE, WAIT_SOF, STREAM.
- IDLE:
  - If no source is enabled, stay in IDLE.
  - Else choose next = ~last_sel if that source is enabled, otherwise last_sel.
  - Load sel=next, clear the timeout counter, go to WAIT_SOF. The choice takes 1 cycle.
- WAIT_SOF:
  - If SOF of sel: go to STREAM. Mid-frame joining is impossible because a rising edge is required.
  - Else if I_src_enable[sel]=0: go to IDLE; last_sel unchanged.
  - Else if the counter reaches Pra_Timeout-1: go to IDLE, last_sel=sel, O_timeout=1 for 1 cycle.
  - Else increment the counter.
- STREAM:
  - Pass the selected source through.
  - On EOF of sel: O_frame_cnt += 1, last_sel=sel, go to IDLE.
  - Deasserting I_src_enable[sel] during STREAM does NOT truncate the frame; it takes effect at the next arbitration.
- Datapath, 1-cycle latency:
  - For input cycle t, if (state==WAIT_SOF && SOF of sel) or state==STREAM, then at t+1 O_image_* = sel inputs at t.
  - Otherwise O_image_* = 0 at t+1.
  - The EOF cycle (vs=0) is forwarded, so O_image_vs falls exactly 1 cycle after the input.
- hs/en/data are forwarded unmodified and are not checked for consistency with vs.
- Between frames from the same source, at least 1 IDLE cycle and the WAIT_SOF wait occur. A source whose next SOF arrives less than 2 cycles after EOF loses that frame.
- O_busy = (state != IDLE). O_sel holds its last value in IDLE.
- Simultaneous SOF on both sources: only sel matters; the other source is ignored.

Test Plan:
- Reset, then both sources enabled. Cam0 sends a 4-line frame (vs high 100 cycles), then cam1 sends 1 frame → output shows cam0 frame delayed by exactly 1 cycle, then cam1 frame. O_frame_cnt 0→1→2, O_sel 0 then 1.
- Only I_src_enable=2'b01; cam0 sends 3 consecutive frames with a 10-cycle gap → all 3 delivered, O_sel=0 throughout, O_frame_cnt=3. Cam1 activity never appears on the output.
- Grant cam0 while its vs is already high (mid-frame) → no output until cam0's next rising vs; that partial frame is dropped, O_frame_cnt unchanged.
- Pra_Timeout=16, cam0 enabled but silent, cam1 enabled and sending → O_timeout pulses 16 cycles after the cam0 grant. Cam1's next frame is delivered, O_sel=1.
- During a cam1 STREAM frame, drop I_src_enable[1] at line 2 → frame completes intact, O_frame_cnt increments. Next grant goes to cam0; cam1 is never re-granted while disabled.
- Assert I_rst for 1 cycle mid-frame → all O_image_* = 0 at the next cycle, O_frame_cnt=0. After reset the first grant goes to cam0.
